// File: rtl/window_valid_gen.sv
// window_valid_gen
//   Sliding-window validity generator for the HOG pixel pipeline. Tracks the
//   column/row of every accepted pixel of an IMG_W x IMG_H raster frame and
//   flags the pixels that complete a WIN_W x WIN_H window lying on a
//   STRIDE_X/STRIDE_Y grid. Also reports the window origin, a per-frame
//   window count and frame boundaries.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   clear      synchronous restart of frame tracking (priority over i_valid)
//   i_valid    pixel accepted this cycle (ignored in DONE)
//   o_valid    accepted pixel completes an on-grid window (combinational)
//   o_col      window top-left column, meaningful only with o_valid
//   o_row      window top-left row, meaningful only with o_valid
//   o_sof      first pixel of the frame accepted (combinational)
//   o_eof      last pixel of the frame accepted (combinational)
//   o_win_cnt  windows flagged so far in the current frame (registered)
//   o_busy     state is FILL or RUN
module window_valid_gen #(
  parameter int unsigned IMG_W        = 160,
  parameter int unsigned IMG_H        = 120,
  parameter int unsigned WIN_W        = 3,
  parameter int unsigned WIN_H        = 3,
  parameter int unsigned STRIDE_X     = 1,
  parameter int unsigned STRIDE_Y     = 1,
  parameter bit          AUTO_RESTART = 1'b1,
  parameter int unsigned CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          i_valid,
  output logic          o_valid,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row,
  output logic          o_sof,
  output logic          o_eof,
  output logic [CW-1:0] o_win_cnt,
  output logic          o_busy
);

  localparam int unsigned XPW = (STRIDE_X > 1) ? $clog2(STRIDE_X) : 1;
  localparam int unsigned YPW = (STRIDE_Y > 1) ? $clog2(STRIDE_Y) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0]  ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0]  WIN_COL  = CW'(WIN_W - 1);
  localparam logic [CW-1:0]  WIN_ROW  = CW'(WIN_H - 1);
  localparam logic [CW:0]    WIN_W_X  = (CW+1)'(WIN_W);
  localparam logic [CW:0]    WIN_H_X  = (CW+1)'(WIN_H);
  localparam logic [XPW-1:0] XPH_LAST = XPW'(STRIDE_X - 1);
  localparam logic [YPW-1:0] YPH_LAST = YPW'(STRIDE_Y - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [CW-1:0]  row_q, row_d;
  logic [XPW-1:0] x_ph_q, x_ph_d;
  logic [YPW-1:0] y_ph_q, y_ph_d;
  logic [CW-1:0]  win_cnt_q, win_cnt_d;

  logic          accept;
  logic          col_wrap;
  logic          col_ok;
  logic          row_ok;
  logic          eof;
  logic          valid;
  logic          sof;
  logic [CW:0]   col_p1;
  logic [CW:0]   row_p1;

  // "col >= WIN_W-1" is evaluated as "col+1 >= WIN_W" so a 1-wide window
  // does not degenerate into an unsigned compare against zero.
  assign col_p1   = {1'b0, col_q} + (CW+1)'(1);
  assign row_p1   = {1'b0, row_q} + (CW+1)'(1);
  assign col_ok   = (col_p1 >= WIN_W_X);
  assign row_ok   = (row_p1 >= WIN_H_X);
  assign col_wrap = (col_q == COL_LAST);

  // Pulses are also gated by rst so nothing fires while reset is held.
  assign accept = rst & i_valid & ~clear & (state_q != ST_DONE);
  assign eof    = accept & col_wrap & (row_q == ROW_LAST);
  assign valid  = accept & col_ok & row_ok & (x_ph_q == '0) & (y_ph_q == '0);
  assign sof    = accept & (col_q == '0) & (row_q == '0);

  assign o_valid   = valid;
  assign o_sof     = sof;
  assign o_eof     = eof;
  assign o_col     = col_q - WIN_COL;
  assign o_row     = row_q - WIN_ROW;
  assign o_win_cnt = win_cnt_q;
  assign o_busy    = (state_q != ST_DONE);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    x_ph_d    = x_ph_q;
    y_ph_d    = y_ph_q;
    win_cnt_d = win_cnt_q;

    if (clear) begin
      state_d   = ST_FILL;
      col_d     = '0;
      row_d     = '0;
      x_ph_d    = '0;
      y_ph_d    = '0;
      win_cnt_d = '0;
    end else begin
      if (accept) begin
        if (eof) begin
          col_d  = '0;
          row_d  = '0;
          x_ph_d = '0;
          y_ph_d = '0;
        end else if (col_wrap) begin
          col_d  = '0;
          row_d  = row_q + CW'(1);
          x_ph_d = '0;
          if (row_ok) begin
            y_ph_d = (y_ph_q == YPH_LAST) ? '0 : y_ph_q + YPW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
          if (col_ok) begin
            x_ph_d = (x_ph_q == XPH_LAST) ? '0 : x_ph_q + XPW'(1);
          end
        end

        // The previous frame's count stays readable until the next frame starts;
        // a 1x1 window can flag the very first pixel, hence the load of o_valid.
        if (sof) begin
          win_cnt_d = CW'(valid);
        end else if (valid) begin
          win_cnt_d = win_cnt_q + CW'(1);
        end
      end

      unique case (state_q)
        ST_FILL: begin
          if (eof)        state_d = ST_DONE;
          else if (valid) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (eof) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (AUTO_RESTART) state_d = ST_FILL;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FILL;
      col_q     <= '0;
      row_q     <= '0;
      x_ph_q    <= '0;
      y_ph_q    <= '0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      x_ph_q    <= x_ph_d;
      y_ph_q    <= y_ph_d;
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule

// File: tb/tb_window_valid_gen.sv
module tb_window_valid_gen;

  localparam int unsigned CW = 16;

  logic clk;
  logic rst;
  logic clr;
  logic iv;

  // d0: 8x6 frame, 3x3 window, stride 1, auto restart
  logic          v0, sof0, eof0, busy0;
  logic [CW-1:0] col0, row0, cnt0;
  // d1: same frame, stride 2x2
  logic          v1, sof1, eof1, busy1;
  logic [CW-1:0] col1, row1, cnt1;
  // d2: same as d0 but holds in DONE
  logic          v2, sof2, eof2, busy2;
  logic [CW-1:0] col2, row2, cnt2;
  // d3: 4x2 frame, 1x1 window
  logic          v3, sof3, eof3, busy3;
  logic [CW-1:0] col3, row3, cnt3;

  window_valid_gen #(.IMG_W(8), .IMG_H(6), .WIN_W(3), .WIN_H(3), .STRIDE_X(1), .STRIDE_Y(1),
                     .AUTO_RESTART(1'b1), .CW(CW)) u_d0 (
    .clk(clk), .rst(rst), .clear(clr), .i_valid(iv), .o_valid(v0), .o_col(col0), .o_row(row0),
    .o_sof(sof0), .o_eof(eof0), .o_win_cnt(cnt0), .o_busy(busy0));

  window_valid_gen #(.IMG_W(8), .IMG_H(6), .WIN_W(3), .WIN_H(3), .STRIDE_X(2), .STRIDE_Y(2),
                     .AUTO_RESTART(1'b1), .CW(CW)) u_d1 (
    .clk(clk), .rst(rst), .clear(clr), .i_valid(iv), .o_valid(v1), .o_col(col1), .o_row(row1),
    .o_sof(sof1), .o_eof(eof1), .o_win_cnt(cnt1), .o_busy(busy1));

  window_valid_gen #(.IMG_W(8), .IMG_H(6), .WIN_W(3), .WIN_H(3), .STRIDE_X(1), .STRIDE_Y(1),
                     .AUTO_RESTART(1'b0), .CW(CW)) u_d2 (
    .clk(clk), .rst(rst), .clear(clr), .i_valid(iv), .o_valid(v2), .o_col(col2), .o_row(row2),
    .o_sof(sof2), .o_eof(eof2), .o_win_cnt(cnt2), .o_busy(busy2));

  window_valid_gen #(.IMG_W(4), .IMG_H(2), .WIN_W(1), .WIN_H(1), .STRIDE_X(1), .STRIDE_Y(1),
                     .AUTO_RESTART(1'b1), .CW(CW)) u_d3 (
    .clk(clk), .rst(rst), .clear(clr), .i_valid(iv), .o_valid(v3), .o_col(col3), .o_row(row3),
    .o_sof(sof3), .o_eof(eof3), .o_win_cnt(cnt3), .o_busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int   pix;
    logic v;
    int   col;
    int   row;
    logic sof;
    logic eof;
    int   cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic apply(input logic v, input logic c);
    iv  = v;
    clr = c;
    #4;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    apply(1'b0, 1'b0);
    adv();
    adv();
    rst = 1'b1;
  endtask

  function automatic logic win3(input int p);
    return ((p % 8) >= 2) && ((p / 8) >= 2);
  endfunction

  initial begin
    int q1[$];
    int exp1[6];
    int nwin;
    int acc;
    int cyc;
    logic rv;
    logic e1;

    // pixel, valid, o_col, o_row, sof, eof, o_win_cnt (8x6 frame, 3x3, stride 1)
    tbl[0] = '{0,  1'b0, 0, 0, 1'b1, 1'b0, 0};
    tbl[1] = '{1,  1'b0, 0, 0, 1'b0, 1'b0, 0};
    tbl[2] = '{17, 1'b0, 0, 0, 1'b0, 1'b0, 0};
    tbl[3] = '{18, 1'b1, 0, 0, 1'b0, 1'b0, 0};
    tbl[4] = '{19, 1'b1, 1, 0, 1'b0, 1'b0, 1};
    tbl[5] = '{23, 1'b1, 5, 0, 1'b0, 1'b0, 5};
    tbl[6] = '{24, 1'b0, 0, 0, 1'b0, 1'b0, 6};
    tbl[7] = '{26, 1'b1, 0, 1, 1'b0, 1'b0, 6};
    tbl[8] = '{47, 1'b1, 5, 3, 1'b0, 1'b1, 23};
    exp1 = '{0, 200, 400, 2, 202, 402};

    // Reset state with i_valid high
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0);
      chk("rst_valid", int'(v0), 0);
      chk("rst_sof", int'(sof0), 0);
      chk("rst_eof", int'(eof0), 0);
      chk("rst_cnt", int'(cnt0), 0);
      chk("rst_busy", int'(busy0), 1);
      adv();
    end
    rst = 1'b1;

    // Continuous frame on all instances
    for (int p = 0; p < 48; p++) begin
      apply(1'b1, 1'b0);
      chk("cont_valid", int'(v0), int'(win3(p)));
      chk("ar0_valid", int'(v2), int'(win3(p)));
      e1 = win3(p) && ((p % 8) % 2 == 0) && ((p / 8) % 2 == 0);
      chk("stride_valid", int'(v1), int'(e1));
      if (v1) q1.push_back(int'(col1) * 100 + int'(row1));
      for (int t = 0; t < 9; t++) begin
        if (tbl[t].pix == p) begin
          chk("tbl_valid", int'(v0), int'(tbl[t].v));
          chk("tbl_sof", int'(sof0), int'(tbl[t].sof));
          chk("tbl_eof", int'(eof0), int'(tbl[t].eof));
          chk("tbl_cnt", int'(cnt0), tbl[t].cnt);
          if (tbl[t].v) begin
            chk("tbl_col", int'(col0), tbl[t].col);
            chk("tbl_row", int'(row0), tbl[t].row);
          end
        end
      end
      if (p < 3) begin
        chk("w1_valid", int'(v3), 1);
        chk("w1_col", int'(col3), p);
        chk("w1_sof", int'(sof3), int'(p == 0));
        chk("w1_cnt", int'(cnt3), p);
      end
      adv();
    end

    chk("stride_nwin", q1.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < q1.size()) chk("stride_origin", q1[k], exp1[k]);
    end

    // DONE cycle, i_valid still high
    apply(1'b1, 1'b0);
    chk("done_busy", int'(busy0), 0);
    chk("done_valid", int'(v0), 0);
    chk("done_sof", int'(sof0), 0);
    chk("done_cnt", int'(cnt0), 24);
    chk("stride_cnt", int'(cnt1), 6);
    chk("stride_busy", int'(busy1), 0);
    chk("ar0_busy", int'(busy2), 0);
    adv();

    // d0 restarted; d2 holds in DONE
    apply(1'b1, 1'b0);
    chk("restart_sof", int'(sof0), 1);
    chk("restart_busy", int'(busy0), 1);
    chk("restart_cnt", int'(cnt0), 24);
    chk("hold_sof", int'(sof2), 0);
    chk("hold_valid", int'(v2), 0);
    chk("hold_busy", int'(busy2), 0);
    adv();
    apply(1'b1, 1'b0);
    chk("restart_cnt_clr", int'(cnt0), 0);
    chk("hold_busy2", int'(busy2), 0);
    chk("hold_sof2", int'(sof2), 0);
    chk("hold_cnt", int'(cnt2), 24);
    adv();
    apply(1'b1, 1'b1);
    chk("clr_valid", int'(v0), 0);
    chk("clr_sof", int'(sof0), 0);
    adv();
    apply(1'b1, 1'b0);
    chk("post_clr_sof", int'(sof0), 1);
    chk("ar0_clr_sof", int'(sof2), 1);
    chk("ar0_clr_busy", int'(busy2), 1);
    chk("ar0_clr_cnt", int'(cnt2), 0);
    adv();

    // clear at pixel 20
    do_reset();
    for (int p = 0; p < 20; p++) begin
      apply(1'b1, 1'b0);
      adv();
    end
    apply(1'b1, 1'b1);
    chk("clr20_valid", int'(v0), 0);
    chk("clr20_sof", int'(sof0), 0);
    chk("clr20_cnt_before", int'(cnt0), 2);
    adv();
    nwin = 0;
    for (int k = 0; k < 48; k++) begin
      apply(1'b1, 1'b0);
      if (k == 0) begin
        chk("clr20_sof_next", int'(sof0), 1);
        chk("clr20_cnt_zero", int'(cnt0), 0);
      end
      chk("clr20_valid_k", int'(v0), int'(win3(k)));
      if (k == 47) chk("clr20_eof", int'(eof0), 1);
      if (v0) nwin++;
      adv();
    end
    chk("clr20_nwin", nwin, 24);
    apply(1'b0, 1'b0);
    chk("clr20_cnt_done", int'(cnt0), 24);
    chk("clr20_busy_done", int'(busy0), 0);
    adv();

    // 50% random i_valid
    do_reset();
    acc = 0;
    cyc = 0;
    nwin = 0;
    while (acc < 48 && cyc < 2000) begin
      rv = 1'($urandom_range(0, 1));
      apply(rv, 1'b0);
      if (!rv) begin
        chk("rnd_idle_valid", int'(v0), 0);
      end else begin
        chk("rnd_valid", int'(v0), int'(win3(acc)));
        if (v0) begin
          chk("rnd_col", int'(col0), (acc % 8) - 2);
          chk("rnd_row", int'(row0), (acc / 8) - 2);
          nwin++;
        end
        acc++;
      end
      adv();
      cyc++;
    end
    chk("rnd_accepts", acc, 48);
    chk("rnd_nwin", nwin, 24);
    apply(1'b0, 1'b0);
    chk("rnd_cnt_done", int'(cnt0), 24);
    adv();

    // reset asserted at pixel 30
    do_reset();
    for (int p = 0; p < 30; p++) begin
      apply(1'b1, 1'b0);
      adv();
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b0);
      chk("mrst_valid", int'(v0), 0);
      chk("mrst_sof", int'(sof0), 0);
      chk("mrst_eof", int'(eof0), 0);
      chk("mrst_cnt", int'(cnt0), 0);
      chk("mrst_busy", int'(busy0), 1);
      adv();
    end
    rst = 1'b1;
    apply(1'b1, 1'b0);
    chk("mrst_sof_next", int'(sof0), 1);
    chk("mrst_valid_next", int'(v0), 0);
    adv();
    apply(1'b0, 1'b0);
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
